// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter/rotator that applies the shift amount one binary
// stage (1, 2, 4, 8, 16 positions) per clock.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst_n    - asynchronous active-low reset
//   start    - request pulse, sampled only while ready=1
//   op       - 00 SLL, 01 SRL, 10 SRA, 11 ROL; sampled with start
//   data_in  - 32-bit operand; sampled with start
//   shamt    - shift amount 0..31; sampled with start
//   ready    - high in IDLE and DONE
//   busy     - high in SHIFT
//   done     - one-cycle pulse in DONE
//   data_out - result, valid with done and held until the next accepted start
//   stage    - stage index applied in the current SHIFT cycle, 0 otherwise
module shift_sequencer #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic [2:0]  stage
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [2:0]  r_k;
  logic [31:0] r_work;
  logic [1:0]  r_op;
  logic [4:0]  r_shamt;

  logic        w_accept;
  logic [4:0]  w_step_amt;
  logic [31:0] w_stepped;
  logic [31:0] w_work_nxt;
  logic [4:0]  w_upper;
  logic        w_last;

  assign w_accept   = ready & start;
  assign w_step_amt = 5'd1 << r_k;

  // One stage of the barrel shift: move by 2^k positions.
  always_comb begin
    w_stepped = r_work;
    unique case (r_op)
      2'b00: w_stepped = r_work << w_step_amt;
      2'b01: w_stepped = r_work >> w_step_amt;
      2'b10: w_stepped = $signed(r_work) >>> w_step_amt;
      default: w_stepped = (r_work << w_step_amt) |
                           (r_work >> (6'd32 - {1'b0, w_step_amt}));
    endcase
  end

  assign w_work_nxt = r_shamt[r_k] ? w_stepped : r_work;

  // Remaining higher shamt bits; zero means the result is already complete.
  assign w_upper = r_shamt >> (r_k + 3'd1);
  assign w_last  = (r_k == 3'd4) || (EARLY_EXIT && (w_upper == 5'd0));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_nxt = (shamt == 5'd0) ? StDone : StShift;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      StShift: begin
        if (w_last) begin
          w_state_nxt = StDone;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    stage    = 3'd0;
    data_out = r_work;
    unique case (r_state)
      StIdle:  ready = 1'b1;
      StShift: begin
        busy  = 1'b1;
        stage = r_k;
      end
      StDone: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_k     <= 3'd0;
      r_work  <= 32'd0;
      r_op    <= 2'd0;
      r_shamt <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_work  <= data_in;
        r_op    <= op;
        r_shamt <= shamt;
        r_k     <= 3'd0;
      end else if (r_state == StShift) begin
        r_work <= w_work_nxt;
        r_k    <= r_k + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic clk;
  logic rst_n;

  logic        start_a, ready_a, busy_a, done_a;
  logic [1:0]  op_a;
  logic [31:0] din_a, dout_a;
  logic [4:0]  sh_a;
  logic [2:0]  stage_a;

  logic        start_b, ready_b, busy_b, done_b;
  logic [1:0]  op_b;
  logic [31:0] din_b, dout_b;
  logic [4:0]  sh_b;
  logic [2:0]  stage_b;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sequencer #(.EARLY_EXIT(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .op(op_a), .data_in(din_a),
    .shamt(sh_a), .ready(ready_a), .busy(busy_a), .done(done_a),
    .data_out(dout_a), .stage(stage_a)
  );

  shift_sequencer #(.EARLY_EXIT(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .op(op_b), .data_in(din_b),
    .shamt(sh_b), .ready(ready_b), .busy(busy_b), .done(done_b),
    .data_out(dout_b), .stage(stage_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                            input logic [4:0] s);
    logic [63:0] dbl;
    case (o)
      2'b00: return d << s;
      2'b01: return d >> s;
      2'b10: return 32'($signed(d) >>> s);
      default: begin
        dbl = {d, d} << s;
        return dbl[63:32];
      end
    endcase
  endfunction

  function automatic int exp_lat(input bit ee, input logic [4:0] s);
    if (s == 5'd0) return 1;
    if (!ee) return 6;
    for (int i = 4; i >= 0; i--) if (s[i]) return 2 + i;
    return 1;
  endfunction

  // Issue one op on the EARLY_EXIT=1 instance; returns result, latency in
  // cycles counted from the accepting edge, and a mask of stages seen.
  task automatic run_a(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                       output logic [31:0] res, output int lat, output logic [7:0] seen);
    op_a = o; din_a = d; sh_a = s; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = 1;
    seen = 8'd0;
    while (!done_a && lat < 20) begin
      if (busy_a) seen[stage_a] = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    res = dout_a;
  endtask

  logic [31:0] res;
  int          lat;
  logic [7:0]  seen;

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; op_a = 2'd0; din_a = 32'd0; sh_a = 5'd0;
    start_b = 1'b0; op_b = 2'd0; din_b = 32'd0; sh_b = 5'd0;
    #1;
    check("rst_ready", {31'd0, ready_a}, 32'd1);
    check("rst_busy",  {31'd0, busy_a},  32'd0);
    check("rst_done",  {31'd0, done_a},  32'd0);
    check("rst_dout",  dout_a, 32'd0);
    check("rst_stage", {29'd0, stage_a}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // SLL 1 by 5: stages 0,1,2 applied, done at accept+4.
    run_a(2'b00, 32'h0000_0001, 5'd5, res, lat, seen);
    check("sll5_data",   res, 32'h0000_0020);
    check("sll5_lat",    lat, 4);
    check("sll5_stages", {24'd0, seen}, 32'h0000_0007);

    run_a(2'b10, 32'h8000_0000, 5'd31, res, lat, seen);
    check("sra31_data", res, 32'hFFFF_FFFF);
    check("sra31_lat",  lat, 6);
    run_a(2'b01, 32'h8000_0000, 5'd31, res, lat, seen);
    check("srl31_data", res, 32'h0000_0001);

    run_a(2'b11, 32'h8000_0001, 5'd4, res, lat, seen);
    check("rol4_data", res, 32'h0000_0018);
    check("rol4_lat",  lat, 4);
    run_a(2'b11, 32'h8000_0001, 5'd0, res, lat, seen);
    check("rol0_data", res, 32'h8000_0001);
    check("rol0_lat",  lat, 1);

    // Idle hold: data_out stays after done.
    @(posedge clk); #1;
    check("idle_done", {31'd0, done_a}, 32'd0);
    check("idle_hold", dout_a, 32'h8000_0001);

    // EARLY_EXIT=0 always runs all five stages.
    op_b = 2'b00; din_b = 32'h0000_0001; sh_b = 5'd1; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    lat = 1;
    while (!done_b && lat < 20) begin @(posedge clk); #1; lat++; end
    check("b_sll1_lat",  lat, 6);
    check("b_sll1_data", dout_b, 32'h0000_0002);
    @(posedge clk); #1;

    // start during SHIFT is ignored; start in DONE is accepted back-to-back.
    op_a = 2'b00; din_a = 32'h0000_0001; sh_a = 5'd16; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    op_a = 2'b01; din_a = 32'hFFFF_FFFF; sh_a = 5'd3; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = 3;
    while (!done_a && lat < 20) begin @(posedge clk); #1; lat++; end
    check("ign_data", dout_a, 32'h0001_0000);
    check("ign_lat",  lat, 6);
    run_a(2'b11, 32'h0000_0001, 5'd1, res, lat, seen);
    check("b2b_data", res, 32'h0000_0002);
    check("b2b_lat",  lat, 2);
    @(posedge clk); #1;
    check("b2b_nodone", {31'd0, done_a}, 32'd0);

    // Asynchronous reset at k=2.
    op_a = 2'b00; din_a = 32'h0000_000F; sh_a = 5'd7; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_stage", {29'd0, stage_a}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout",  dout_a, 32'd0);
    check("arst_busy",  {31'd0, busy_a},  32'd0);
    check("arst_ready", {31'd0, ready_a}, 32'd1);
    check("arst_stage", {29'd0, stage_a}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_nodone0", {31'd0, done_a}, 32'd0);
    @(posedge clk); #1;
    check("arst_nodone1", {31'd0, done_a}, 32'd0);
    run_a(2'b01, 32'hF000_0000, 5'd4, res, lat, seen);
    check("post_srl_data", res, 32'h0F00_0000);
    check("post_srl_lat",  lat, 4);
    @(posedge clk); #1;

    // Randomized ops on both instances in parallel.
    fork
      begin : rand_a
        logic [31:0] last;
        int la;
        for (int i = 0; i < 5000; i++) begin
          op_a = 2'($urandom); din_a = $urandom; sh_a = 5'($urandom);
          start_a = 1'b1;
          @(posedge clk); #1;
          start_a = 1'b0;
          la = 1;
          while (!done_a && la < 20) begin @(posedge clk); #1; la++; end
          check("rnd_a_data", dout_a, ref_shift(op_a, din_a, sh_a));
          check("rnd_a_lat",  la, exp_lat(1'b1, sh_a));
          if ($urandom_range(3) == 0) begin
            last = dout_a;
            @(posedge clk); #1;
            check("rnd_a_hold", dout_a, last);
          end
        end
      end
      begin : rand_b
        int lb;
        for (int i = 0; i < 5000; i++) begin
          op_b = 2'($urandom); din_b = $urandom; sh_b = 5'($urandom);
          start_b = 1'b1;
          @(posedge clk); #1;
          start_b = 1'b0;
          lb = 1;
          while (!done_b && lb < 20) begin @(posedge clk); #1; lb++; end
          check("rnd_b_data", dout_b, ref_shift(op_b, din_b, sh_b));
          check("rnd_b_lat",  lb, exp_lat(1'b0, sh_b));
        end
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter EARLY_EXIT, default 1, meaning 1 = finish as soon as no higher shamt bits remain and 0 = always run all 5 stages.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, request pulse; sampled only while ready=1.
REQ-005 SHALL have port op, input, 2, 00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left); sampled with start.
REQ-006 SHALL have port data_in, input, 32, operand; sampled with start.
REQ-007 SHALL have port shamt, input, 5, shift amount 0..31; sampled with start.
REQ-008 SHALL have port ready, output, 1, high in IDLE and DONE.
REQ-009 SHALL have port busy, output, 1, high in SHIFT.
REQ-010 SHALL have port done, output, 1, one-cycle pulse, high only in DONE.
REQ-011 SHALL have port data_out, output, 32, result; valid when done=1 and held until the next accepted start.
REQ-012 SHALL have port stage, output, 3, index (0..4) of the stage applied in the current SHIFT cycle; 0 outside SHIFT.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE, with a 3-bit stage counter k, a 32-bit work register, and latched op and shamt.
REQ-014 SHALL accept start only when ready=1: IDLE or DONE with start -> load work=data_in, latch op/shamt, k=0, then go to SHIFT, or directly to DONE when shamt=0.
REQ-015 SHALL ignore start while busy=1, leaving latched operands unchanged.
REQ-016 SHALL, in each SHIFT cycle, update work by 2^k positions if shamt[k]=1 and leave it unchanged otherwise, then increment k.
REQ-017 SHALL fill shifts as follows: SLL zero-fills LSBs; SRL zero-fills MSBs; SRA fills with the work register's bit 31; ROL wraps bits shifted out of bit 31 into the LSBs.
REQ-018 SHALL, after the k=4 cycle, go from SHIFT to DONE.
REQ-019 SHALL, with EARLY_EXIT=1, go from SHIFT to DONE after cycle k when shamt[4:k+1]=0.
REQ-020 SHALL go from DONE to IDLE with no start, or to SHIFT/DONE as in REQ-014 with start; this gives back-to-back operation with no idle cycle.
REQ-021 SHALL set latency from accepting edge to done=1 as 1 + N cycles, where N = 5 (EARLY_EXIT=0) or N = 1 + index of shamt's highest set bit (EARLY_EXIT=1, 0 when shamt=0).
REQ-022 SHALL drive data_out from the work register; it equals the final result in DONE and is unchanged during IDLE.
REQ-023 SHALL produce, for every op/shamt, a result bit-identical to a single-cycle 32-bit barrel shift.

Reset
REQ-024 SHALL, while rst_n=0, immediately force state=IDLE, k=0, work=0, latched op/shamt=0, ready=1, busy=0, done=0, data_out=0, stage=0.
REQ-025 SHALL, on reset mid-SHIFT or in DONE, abort the operation with no done pulse afterwards; the first edge after deassertion may accept start.

Verification
REQ-026 SHALL verify: SLL, data_in=0x0000_0001, shamt=5, EARLY_EXIT=1 -> stage 0,1,2 seen, done at accept+4, data_out=0x0000_0020.
REQ-027 SHALL verify: SRA, data_in=0x8000_0000, shamt=31 -> done at accept+6, data_out=0xFFFF_FFFF; the same input with SRL -> 0x0000_0001.
REQ-028 SHALL verify: ROL, data_in=0x8000_0001, shamt=4 -> data_out=0x0000_0018; shamt=0 -> done at accept+1, data_out=0x8000_0001.
REQ-029 SHALL verify: start pulsed with new operands during SHIFT -> ignored, first result intact; start asserted in DONE -> second op accepted, done pulses on both ops, never two consecutive done cycles for one op.
REQ-030 SHALL verify: rst_n low at k=2 of an SLL -> outputs zero asynchronously, no done; a following SRL of 0xF000_0000 by 4 -> 0x0F00_0000.
REQ-031 SHALL verify: randomized 10k ops, both EARLY_EXIT values, compared to a reference model -> zero mismatches, latency per REQ-021.
